// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state type and sizing helper for the ALU op sequencer.
package alu_seq_pkg;

   localparam logic [3:0] ALU_DIV     = 4'b0000;
   localparam logic [3:0] ALU_MUL     = 4'b0001;
   localparam logic [3:0] ALU_SUB     = 4'b0010;
   localparam logic [3:0] ALU_ADD     = 4'b0011;
   localparam logic [3:0] ALU_OR      = 4'b0100;
   localparam logic [3:0] ALU_AND     = 4'b0101;
   localparam logic [3:0] ALU_BNE     = 4'b0110;
   localparam logic [3:0] ALU_BGT     = 4'b0111;
   localparam logic [3:0] ALU_BLT     = 4'b1000;
   localparam logic [3:0] ALU_INVALID = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold the value n-1 (call with WIDTH+1 to hold WIDTH).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier / restoring divider sharing one 2*WIDTH shift
// register and one adder; one step per cycle for WIDTH cycles after i_start.
module iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_start,
   input  logic             i_mode_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   localparam int CW = clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_operand;
   logic               r_mode_div;
   logic [CW-1:0]      r_cnt;

   logic [WIDTH-1:0]   w_hi;
   logic [WIDTH-1:0]   w_lo;
   logic [WIDTH:0]     w_x;
   logic [WIDTH:0]     w_y;
   logic [WIDTH+1:0]   w_sum;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_acc_nxt;

   assign w_hi = r_acc[2*WIDTH-1:WIDTH];
   assign w_lo = r_acc[WIDTH-1:0];

   // Div: partial remainder shifted left against divisor (x - d = x + ~d + 1).
   // Mul: high half plus multiplicand when the current multiplier bit is set.
   always_comb begin
      w_x = {1'b0, w_hi};
      w_y = '0;
      if (r_mode_div) begin
         w_x = {w_hi, w_lo[WIDTH-1]};
         w_y = ~{1'b0, r_operand};
      end else if (w_lo[0]) begin
         w_y = {1'b0, r_operand};
      end
   end

   assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {{(WIDTH+1){1'b0}}, r_mode_div};
   assign w_fits = w_sum[WIDTH+1];

   always_comb begin
      if (r_mode_div) begin
         w_acc_nxt[2*WIDTH-1:WIDTH] = w_fits ? w_sum[WIDTH-1:0] : w_x[WIDTH-1:0];
         w_acc_nxt[WIDTH-1:0]       = {w_lo[WIDTH-2:0], w_fits};
      end else begin
         w_acc_nxt = {w_sum[WIDTH:0], w_lo[WIDTH-1:1]};
      end
   end

   // The final step's result is presented combinationally alongside o_done.
   assign o_done = (r_cnt == CW'(1));
   assign o_lo   = w_acc_nxt[WIDTH-1:0];
   assign o_hi   = w_acc_nxt[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_acc      <= '0;
         r_operand  <= '0;
         r_mode_div <= 1'b0;
         r_cnt      <= '0;
      end else if (i_flush) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_acc      <= {{WIDTH{1'b0}}, (i_mode_div ? i_a : i_b)};
         r_operand  <= i_mode_div ? i_b : i_a;
         r_mode_div <= i_mode_div;
         r_cnt      <= CW'(WIDTH);
      end else if (r_cnt != '0) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time: single-cycle ops complete next cycle, mul/div
// iterate WIDTH steps; valid/ready on both sides stalls issue while busy.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [3:0]       i_alu_control,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [WIDTH-1:0] o_result_hi,
   output logic             o_branch_taken,
   output logic             o_zero,
   output logic             o_error
);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_branch_taken;
   logic             r_zero;
   logic             r_error;

   logic             w_iter_op;
   logic             w_start;
   logic             w_load_single;
   logic             w_load_iter;
   logic             w_md_done;
   logic [WIDTH-1:0] w_md_lo;
   logic [WIDTH-1:0] w_md_hi;

   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_res;
   logic [WIDTH-1:0] w_res_hi;
   logic             w_branch;
   logic             w_err;

   // Divide by zero takes the single-cycle path.
   assign w_iter_op = (i_alu_control == ALU_MUL) ||
                      ((i_alu_control == ALU_DIV) && (i_operand_b != '0));

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_start       = 1'b0;
      w_load_single = 1'b0;
      w_load_iter   = 1'b0;
      o_in_ready    = 1'b0;
      o_out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            o_in_ready = !i_flush;
            if (i_in_valid && !i_flush) begin
               if (w_iter_op) begin
                  w_start     = 1'b1;
                  w_state_nxt = ITER;
               end else begin
                  w_load_single = 1'b1;
                  w_state_nxt   = DONE;
               end
            end
         end
         ITER: begin
            if (w_md_done && !i_flush) begin
               w_load_iter = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (i_flush) w_state_nxt = IDLE;
   end

   assign w_diff = i_operand_a - i_operand_b;

   always_comb begin
      w_res    = '0;
      w_res_hi = '0;
      w_branch = 1'b0;
      w_err    = 1'b0;
      case (i_alu_control)
         ALU_DIV: begin
            w_res    = '1;
            w_res_hi = i_operand_a;
            w_err    = 1'b1;
         end
         ALU_MUL: ;
         ALU_SUB: w_res = w_diff;
         ALU_ADD: w_res = i_operand_a + i_operand_b;
         ALU_OR:  w_res = i_operand_a | i_operand_b;
         ALU_AND: w_res = i_operand_a & i_operand_b;
         ALU_BNE: begin
            w_res    = w_diff;
            w_branch = (i_operand_a != i_operand_b);
         end
         ALU_BGT: begin
            w_res    = w_diff;
            w_branch = ($signed(i_operand_a) > $signed(i_operand_b));
         end
         ALU_BLT: begin
            w_res    = w_diff;
            w_branch = ($signed(i_operand_a) < $signed(i_operand_b));
         end
         default: w_err = 1'b1;
      endcase
   end

   iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_iter_muldiv (
      .i_clk      (i_clock),
      .i_rst_n    (i_reset_n),
      .i_flush    (i_flush),
      .i_start    (w_start),
      .i_mode_div (i_alu_control == ALU_DIV),
      .i_a        (i_operand_a),
      .i_b        (i_operand_b),
      .o_done     (w_md_done),
      .o_lo       (w_md_lo),
      .o_hi       (w_md_hi)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_result       <= '0;
         r_result_hi    <= '0;
         r_branch_taken <= 1'b0;
         r_zero         <= 1'b0;
         r_error        <= 1'b0;
      end else if (w_load_single) begin
         r_result       <= w_res;
         r_result_hi    <= w_res_hi;
         r_branch_taken <= w_branch;
         r_zero         <= (w_res == '0);
         r_error        <= w_err;
      end else if (w_load_iter) begin
         r_result       <= w_md_lo;
         r_result_hi    <= w_md_hi;
         r_branch_taken <= 1'b0;
         r_zero         <= (w_md_lo == '0);
         r_error        <= 1'b0;
      end
   end

   assign o_result       = r_result;
   assign o_result_hi    = r_result_hi;
   assign o_branch_taken = r_branch_taken;
   assign o_zero         = r_zero;
   assign o_error        = r_error;

endmodule
